// File: rtl/fc_argmax.sv
// fc_argmax: classification back end for the CNN pipeline.
// Consumes one signed class score per valid beat (class 0..OUTPUT_NUM-1 in
// order). After the last class of a frame it publishes the winning index and
// score, pulses valid_out for one cycle and bumps a wrapping frame counter.
// Two-stage pipeline: an input register, then a compare/accumulate stage.
// All outputs come straight from flops.
module fc_argmax #(
    parameter int OUTPUT_NUM = 10,
    parameter int SCORE_BITS = 12,
    parameter int IDX_BITS   = 4,
    parameter int CNT_BITS   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_in,
    input  logic signed [SCORE_BITS-1:0] score_in,
    input  logic                         clear,
    output logic                         valid_out,
    output logic        [IDX_BITS-1:0]   decision,
    output logic signed [SCORE_BITS-1:0] max_score,
    output logic        [CNT_BITS-1:0]   frame_count
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(OUTPUT_NUM - 1);

    typedef enum logic {
        ST_IDLE,   // cnt == 0, no partial frame held
        ST_ACCUM   // at least one score of the current frame accepted
    } state_t;

    state_t state_q, state_d;

    // Stage 1: input register
    logic                         s_valid_q, s_valid_d;
    logic signed [SCORE_BITS-1:0] s_score_q, s_score_d;

    // Stage 2: running maximum of the current frame
    logic        [IDX_BITS-1:0]   cnt_q, cnt_d;
    logic signed [SCORE_BITS-1:0] best_q, best_d;
    logic        [IDX_BITS-1:0]   best_idx_q, best_idx_d;

    // Published results
    logic                         valid_out_q, valid_out_d;
    logic        [IDX_BITS-1:0]   decision_q, decision_d;
    logic signed [SCORE_BITS-1:0] max_score_q, max_score_d;
    logic        [CNT_BITS-1:0]   frame_count_q, frame_count_d;

    // Shared stage-2 decode
    logic                         accept;     // stage-1 beat is processed this edge
    logic                         last_beat;  // stage-1 beat is the final class
    logic                         complete;   // frame finishes this edge
    logic                         take_new;   // stage-1 score becomes the winner
    logic signed [SCORE_BITS-1:0] win_score;
    logic        [IDX_BITS-1:0]   win_idx;

    // Winner including the beat currently in stage 1; clear drops that beat.
    always_comb begin
        accept    = s_valid_q & ~clear;
        last_beat = (cnt_q == LAST_IDX);
        complete  = accept & last_beat;
        // The first beat of a frame wins unconditionally; afterwards only a
        // strictly greater score replaces the leader, so ties keep the lower index.
        take_new  = (state_q == ST_IDLE) || (s_score_q > best_q);
        win_score = take_new ? s_score_q : best_q;
        if (state_q == ST_IDLE) begin
            win_idx = '0;
        end else if (take_new) begin
            win_idx = cnt_q;
        end else begin
            win_idx = best_idx_q;
        end
    end

    // Next-state logic for the frame tracking FSM.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (clear || complete) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath next-state: input stage, running maximum and result registers.
    always_comb begin
        s_valid_d     = valid_in & ~clear;
        s_score_d     = valid_in ? score_in : s_score_q;

        cnt_d         = cnt_q;
        best_d        = best_q;
        best_idx_d    = best_idx_q;

        valid_out_d   = 1'b0;
        decision_d    = decision_q;
        max_score_d   = max_score_q;
        frame_count_d = frame_count_q;

        if (clear) begin
            // Abandon the partial frame; best/best_idx are reloaded by the
            // next index-0 beat, so they are simply left alone here.
            cnt_d = '0;
        end else if (accept) begin
            best_d     = win_score;
            best_idx_d = win_idx;
            cnt_d      = last_beat ? '0 : cnt_q + 1'b1;
        end

        if (complete) begin
            valid_out_d   = 1'b1;
            decision_d    = win_idx;
            max_score_d   = win_score;
            frame_count_d = frame_count_q + 1'b1;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s_valid_q     <= 1'b0;
            s_score_q     <= '0;
            cnt_q         <= '0;
            best_q        <= '0;
            best_idx_q    <= '0;
            valid_out_q   <= 1'b0;
            decision_q    <= '0;
            max_score_q   <= '0;
            frame_count_q <= '0;
        end else begin
            s_valid_q     <= s_valid_d;
            s_score_q     <= s_score_d;
            cnt_q         <= cnt_d;
            best_q        <= best_d;
            best_idx_q    <= best_idx_d;
            valid_out_q   <= valid_out_d;
            decision_q    <= decision_d;
            max_score_q   <= max_score_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign valid_out   = valid_out_q;
    assign decision    = decision_q;
    assign max_score   = max_score_q;
    assign frame_count = frame_count_q;

endmodule
